alu_mc: RTL and testbench

Multi-cycle, handshaked successor to the core's combinational ALU: same 4-bit opcode space, operand and flag semantics, now parametrised in width and extended with iterative multiply and unsigned divide. Sits between the operand stack and the writeback stage; accepts one operation at a time over a valid/ready pair and returns a registered result with carry/overflow flags over a second valid/ready pair.

---
 rtl/alu_mc_pkg.sv | 11 +
 rtl/alu_mc_iter.sv | 64 ++++++
 rtl/alu_mc.sv | 118 +++++++++++
 tb/tb_alu_mc.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared opcode/state enums and shift-amount width helper for alu_mc
package alu_mc_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_SHL,
    OP_SHR, OP_SAR, OP_MUL, OP_MULH, OP_DIVU, OP_REMU, OP_RSV14, OP_RSV15
  } op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic int shamt_bits(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative datapath, one shift-add multiply or restoring divide step per cycle
// Ports: clk, reset (sync, active-high), start loads a/b (div selects divide, present only
// with ALU_MC_DIV_EN), done flags the final step, res is the accumulator after this step
// ({hi,lo} = product, or {remainder,quotient}).
module alu_mc_iter import alu_mc_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef ALU_MC_DIV_EN
  input  logic                 div,
`endif
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   res
);
  localparam int S = shamt_bits(WIDTH);
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m;
  logic [S-1:0]       cnt;
  logic               run;
  logic [WIDTH:0]     sum;
`ifdef ALU_MC_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     dif;
`endif
  // Multiply consumes the multiplier from the low half LSB-first while the
  // partial product shifts in from the top; divide shifts the dividend left
  // into the remainder half and shifts quotient bits in at the bottom.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : {WIDTH{1'b0}}};
    res = {sum, acc[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    dif = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, m};
    if (div_q) res = dif[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`endif
    done = run && cnt == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
      m   <= '0;
`ifdef ALU_MC_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      run <= 1'b1;
      cnt <= S'(WIDTH-1);
      acc <= {{WIDTH{1'b0}}, a};
      m   <= b;
`ifdef ALU_MC_DIV_EN
      div_q <= div;
`endif
    end else if (run) begin
      acc <= res;
      cnt <= cnt - 1'b1;
      run <= cnt != '0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked multi-cycle ALU (add/sub/logic/shift single-cycle, mul/div iterative)
// Ports: clk, reset (sync, active-high); request in_valid/in_ready with a, b, ic, opcode;
// response out_valid/out_ready with out, oc (carry), oo (overflow/exception).
// Define ALU_MC_DIV_EN to build the DIVU/REMU divider; otherwise opcodes 12-13 are reserved.
module alu_mc import alu_mc_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ic,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             oc,
  output logic             oo
);
  localparam int S = shamt_bits(WIDTH);
  state_e               state, state_n;
  op_e                  op, op_q;
  logic [WIDTH-1:0]     bb, r, mc_r;
  logic                 cin, c, o, mc_o, multi, dz, accept, start, idone;
  logic [WIDTH:0]       sum, shl, shr, sar;
  logic [S-1:0]         sh;
  logic [2*WIDTH-1:0]   ires;
  // Shifts run one bit wider than the operand so the last bit shifted out
  // lands in the extra bit; a zero shift leaves that bit 0.
  always_comb begin
    op  = op_e'(opcode);
    bb  = (op == OP_SUB || op == OP_SUBC) ? ~b : b;
    cin = (op == OP_ADDC || op == OP_SUBC) ? ic : op == OP_SUB;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
    sh  = b[S-1:0];
    shl = {1'b0, a} << sh;
    shr = {a, 1'b0} >> sh;
    sar = $signed({a, 1'b0}) >>> sh;
    dz  = 1'b0;
    multi = op == OP_MUL || op == OP_MULH;
`ifdef ALU_MC_DIV_EN
    dz  = b == '0;
    multi = multi || ((op == OP_DIVU || op == OP_REMU) && !dz);
`endif
    r = '0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        o = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: begin r = shl[WIDTH-1:0]; c = shl[WIDTH]; end
      OP_SHR: begin r = shr[WIDTH:1];   c = shr[0];     end
      OP_SAR: begin r = sar[WIDTH:1];   c = sar[0];     end
`ifdef ALU_MC_DIV_EN
      OP_DIVU: begin r = '1; o = 1'b1; end
      OP_REMU: begin r = a;  o = 1'b1; end
`endif
      default: o = 1'b1;
    endcase
    mc_r = (op_q == OP_MUL || op_q == OP_DIVU) ? ires[WIDTH-1:0] : ires[2*WIDTH-1:WIDTH];
    mc_o = (op_q == OP_MUL || op_q == OP_MULH) && |ires[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  // A consumer taking the result frees the block in the same cycle, so a
  // held request is accepted straight out of DONE.
  always_comb begin
    out_valid = state == DONE;
    in_ready  = state == IDLE || (state == DONE && out_ready);
    accept    = in_valid && in_ready;
    start     = accept && multi;
    state_n   = state;
    if (accept)                       state_n = multi ? BUSY : DONE;
    else if (state == BUSY && idone)  state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_ADD;
      out  <= '0;
      oc   <= 1'b0;
      oo   <= 1'b0;
    end else begin
      if (accept) op_q <= op;
      if (accept && !multi) begin
        out <= r;
        oc  <= c;
        oo  <= o;
      end else if (idone) begin
        out <= mc_r;
        oc  <= 1'b0;
        oo  <= mc_o;
      end
    end
  end
  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef ALU_MC_DIV_EN
    .div   (op == OP_DIVU || op == OP_REMU),
`endif
    .a     (a),
    .b     (b),
    .done  (idone),
    .res   (ires)
  );
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=32
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, ic, out_valid, out_ready, oc, oo;
  logic [31:0] a, b, out;
  logic [3:0]  opcode;
  int          n_tests = 0;
  int          n_fail = 0;
  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ic(ic), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .oc(oc), .oo(oo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic c);
    opcode = op; a = x; b = y; ic = c; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic c, input logic [31:0] e_out, input logic e_oc, input logic e_oo, input int e_lat);
    int lat;
    send(op, x, y, c);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, 64'(lat), 64'(e_lat));
    check({tag, "/out"}, {32'h0, out}, {32'h0, e_out});
    check({tag, "/oc"},  {63'h0, oc}, {63'h0, e_oc});
    check({tag, "/oo"},  {63'h0, oo}, {63'h0, e_oo});
    @(posedge clk); #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ic = 1'b0; a = '0; b = '0; opcode = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst/out_valid", {63'h0, out_valid}, 64'h0);
    check("rst/in_ready", {63'h0, in_ready}, 64'h1);
    check("rst/out", {32'h0, out}, 64'h0);
    check("rst/flags", {62'h0, oc, oo}, 64'h0);
    run("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0,         1'b1, 1'b0, 1);
    run("add_ovf",   4'd0,  32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1);
    run("addc",      4'd1,  32'h5,         32'h3, 1'b1, 32'h9,         1'b0, 1'b0, 1);
    run("subc",      4'd3,  32'h5,         32'h3, 1'b0, 32'h1,         1'b1, 1'b0, 1);
    run("sub_brw",   4'd2,  32'h3,         32'h5, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    run("sub_ovf",   4'd2,  32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1);
    run("and",       4'd4,  32'hF0F0,      32'hFF00, 1'b0, 32'hF000,   1'b0, 1'b0, 1);
    run("xor",       4'd6,  32'hF0F0,      32'hFF00, 1'b0, 32'h0FF0,   1'b0, 1'b0, 1);
    run("shr",       4'd8,  32'h3,         32'h1, 1'b0, 32'h1,         1'b1, 1'b0, 1);
    run("shl0",      4'd7,  32'h8000_0001, 32'h20, 1'b0, 32'h8000_0001, 1'b0, 1'b0, 1);
    run("sar",       4'd9,  32'h8000_0008, 32'h4, 1'b0, 32'hF800_0000, 1'b1, 1'b0, 1);
    run("mul_ovf",   4'd10, 32'h1_0000,    32'h1_0000, 1'b0, 32'h0,    1'b0, 1'b1, 33);
    run("mulh",      4'd11, 32'h1_0000,    32'h1_0000, 1'b0, 32'h1,    1'b0, 1'b1, 33);
    run("mul",       4'd10, 32'h7,         32'h6, 1'b0, 32'd42,        1'b0, 1'b0, 33);
    run("mul_big",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h1, 1'b0, 1'b1, 33);
    run("mulh_big",  4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 33);
`ifdef ALU_MC_DIV_EN
    run("divu",      4'd12, 32'd100,       32'd7, 1'b0, 32'd14,        1'b0, 1'b0, 33);
    run("remu",      4'd13, 32'd100,       32'd7, 1'b0, 32'd2,         1'b0, 1'b0, 33);
    run("divu_big",  4'd12, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 1'b0, 1'b0, 33);
    run("divu_z",    4'd12, 32'd9,         32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    run("remu_z",    4'd13, 32'd9,         32'd0, 1'b0, 32'd9,         1'b0, 1'b1, 1);
`else
    run("divu_off",  4'd12, 32'd100,       32'd7, 1'b0, 32'h0,         1'b0, 1'b1, 1);
    run("remu_off",  4'd13, 32'd100,       32'd7, 1'b0, 32'h0,         1'b0, 1'b1, 1);
`endif
    run("rsv14",     4'd14, 32'h1234,      32'h5, 1'b1, 32'h0,         1'b0, 1'b1, 1);
    // stall: hold result while a new request waits on in_ready
    out_ready = 1'b0;
    send(4'd7, 32'h8000_0001, 32'h1, 1'b0);
    opcode = 4'd0; a = 32'h1; b = 32'h1; ic = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall/valid", {63'h0, out_valid}, 64'h1);
      check("stall/ready", {63'h0, in_ready}, 64'h0);
      check("stall/out", {31'h0, oc, out}, {31'h0, 1'b1, 32'h2});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    check("stall_next/out", {31'h0, oc, out}, {31'h0, 1'b0, 32'h2});
    check("stall_next/valid", {63'h0, out_valid}, 64'h1);
    @(posedge clk); #1;
    check("idle/valid", {63'h0, out_valid}, 64'h0);
    // back-to-back single-cycle ops, one result per cycle
    opcode = 4'd0; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b0", {32'h0, out}, 64'd30);
    opcode = 4'd5; a = 32'hF0; b = 32'h0F;
    @(posedge clk); #1;
    check("b2b1", {32'h0, out}, 64'hFF);
    opcode = 4'd2; a = 32'd9; b = 32'd4;
    @(posedge clk); #1 in_valid = 1'b0;
    check("b2b2", {31'h0, oc, out}, {31'h0, 1'b1, 32'd5});
    @(posedge clk); #1;
    // reset during multiply discards the pending result
    send(4'd10, 32'h3, 32'h5, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rstmul/valid", {63'h0, out_valid}, 64'h0);
    check("rstmul/ready", {63'h0, in_ready}, 64'h1);
    repeat (40) @(posedge clk);
    #1 check("rstmul/stale", {63'h0, out_valid}, 64'h0);
    run("after_rst", 4'd0, 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
